sram_2p_req_adapter: RTL and testbench

- Ready/valid front end for the 1-write/1-read register-file macro wrapper (W0_*/R0_* port set, 1-cycle read latency, byte write mask).
- Sits between the core/cache memory client and that wrapper. Converts independent write and read request channels into macro enables.
- Tracks in-flight reads and buffers read responses under backpressure.
- Forwards same-cycle write data into colliding reads, because the macro returns old data on read-during-write to the same address.

---
 rtl/sram_adapter_pkg.sv | 22 ++
 rtl/sram_resp_fifo.sv | 59 +++++
 rtl/sram_2p_req_adapter.sv | 123 ++++++++++++
 tb/tb_sram_2p_req_adapter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_adapter_pkg.sv
// Shared widths, mask-width helper and request/response types for the 1W/1R SRAM adapter.
package sram_adapter_pkg;

  localparam int ADDR_W_DEF     = 10;
  localparam int DATA_W_DEF     = 32;
  localparam int RESP_DEPTH_DEF = 2;

  function automatic int mask_w(input int data_w);
    return data_w / 8;
  endfunction

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
  } rd_rsp_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0]         addr;
    logic [DATA_W_DEF-1:0]         data;
    logic [DATA_W_DEF/8-1:0]       mask;
  } wr_req_t;

endpackage

// File: rtl/sram_resp_fifo.sv
// Response FIFO with fall-through when empty; 0-cycle bypass, 1-cycle when stored.
// Holds data while out_rdy is low; caller guarantees no push when full (credit scheme).
module sram_resp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat,
  input  logic             out_rdy,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Empty buffer lets incoming data bypass; it is only stored if not taken this cycle.
  assign w_empty = (r_count == '0);
  assign w_pop   = ~w_empty & out_rdy;
  assign w_push  = in_vld & ~(w_empty & out_rdy);
  assign out_vld = w_empty ? in_vld : 1'b1;
  assign out_dat = w_empty ? in_dat : r_mem[r_rd_ptr];
  assign count   = r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= in_dat;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sram_2p_req_adapter.sv
// Ready/valid front end for a 1W/1R SRAM macro: writes never stall, reads respond 1 cycle later,
// credit-limited by the response buffer; SRAM_ADAPTER_PERF_EN adds read/write/stall counters.
module sram_2p_req_adapter
  import sram_adapter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RESP_DEPTH = RESP_DEPTH_DEF,
  localparam int MASK_W    = mask_w(DATA_W)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [MASK_W-1:0] wr_mask,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              W0_en,
  output logic [ADDR_W-1:0] W0_addr,
  output logic [DATA_W-1:0] W0_data,
  output logic [MASK_W-1:0] W0_mask,
  output logic              R0_en,
  output logic [ADDR_W-1:0] R0_addr,
  input  logic [DATA_W-1:0] R0_data
`ifdef SRAM_ADAPTER_PERF_EN
  ,
  output logic [31:0]       perf_rd_cnt,
  output logic [31:0]       perf_wr_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  logic              r_alive;
  logic              r_inflight;
  logic [MASK_W-1:0] r_col_mask;
  logic [DATA_W-1:0] r_col_data;
  logic              w_wr_fire;
  logic              w_rd_fire;
  logic              w_collide;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W:0]    w_occ;
  logic [DATA_W-1:0] w_merged;
  logic              w_fifo_vld;
  logic [DATA_W-1:0] w_fifo_dat;

  assign wr_ready  = r_alive;
  assign w_wr_fire = wr_valid & r_alive;
  assign W0_en     = w_wr_fire;
  assign W0_addr   = wr_addr;
  assign W0_data   = wr_data;
  assign W0_mask   = wr_mask;

  // A read is only issued when a buffer slot is guaranteed for its response.
  assign w_occ     = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
  assign rd_ready  = r_alive & (w_occ < (CNT_W+1)'(RESP_DEPTH));
  assign w_rd_fire = rd_valid & rd_ready;
  assign R0_en     = w_rd_fire;
  assign R0_addr   = rd_addr;

  // The macro returns pre-write data on same-address read/write, so patch in written bytes.
  assign w_collide = w_wr_fire & w_rd_fire & (wr_addr == rd_addr);

  always_comb begin
    w_merged = R0_data;
    for (int b = 0; b < MASK_W; b++) begin
      if (r_col_mask[b]) w_merged[8*b +: 8] = r_col_data[8*b +: 8];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_alive    <= 1'b0;
      r_inflight <= 1'b0;
      r_col_mask <= '0;
      r_col_data <= '0;
    end else begin
      r_alive    <= 1'b1;
      r_inflight <= w_rd_fire;
      r_col_mask <= w_collide ? wr_mask : '0;
      if (w_collide) r_col_data <= wr_data;
    end
  end

  sram_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .in_vld  (r_inflight),
    .in_dat  (w_merged),
    .out_vld (w_fifo_vld),
    .out_dat (w_fifo_dat),
    .out_rdy (rsp_ready),
    .count   (w_count)
  );

  assign rsp_valid = w_fifo_vld;
  assign rsp_data  = w_fifo_vld ? w_fifo_dat : '0;

`ifdef SRAM_ADAPTER_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_rd_cnt    <= '0;
      perf_wr_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (w_rd_fire)            perf_rd_cnt    <= perf_rd_cnt + 32'd1;
      if (w_wr_fire)            perf_wr_cnt    <= perf_wr_cnt + 32'd1;
      if (rd_valid & ~rd_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_2p_req_adapter.sv
// Directed bench for sram_2p_req_adapter with a behavioural 1W/1R macro model (read-before-write).
module tb_sram_2p_req_adapter;

  logic        clock;
  logic        reset_n;
  logic        wr_valid, wr_ready;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic        rd_valid, rd_ready;
  logic [9:0]  rd_addr;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        W0_en, R0_en;
  logic [9:0]  W0_addr, R0_addr;
  logic [31:0] W0_data, R0_data;
  logic [3:0]  W0_mask;
`ifdef SRAM_ADAPTER_PERF_EN
  logic [31:0] perf_rd_cnt, perf_wr_cnt, perf_stall_cnt;
`endif

  logic [31:0] mem [1024];
  int          n_tests;
  int          n_fail;

  sram_2p_req_adapter u_dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_mask   (wr_mask),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_addr   (rd_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .W0_en     (W0_en),
    .W0_addr   (W0_addr),
    .W0_data   (W0_data),
    .W0_mask   (W0_mask),
    .R0_en     (R0_en),
    .R0_addr   (R0_addr),
    .R0_data   (R0_data)
`ifdef SRAM_ADAPTER_PERF_EN
    ,
    .perf_rd_cnt    (perf_rd_cnt),
    .perf_wr_cnt    (perf_wr_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Macro model: read returns the pre-write contents on a same-cycle collision.
  always @(posedge clock) begin
    if (R0_en) R0_data <= mem[R0_addr];
    if (W0_en) begin
      for (int b = 0; b < 4; b++)
        if (W0_mask[b]) mem[W0_addr][8*b +: 8] <= W0_data[8*b +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    wr_mask  = '0;
    rd_addr  = '0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 1024; i++) mem[i] = i * 32'h1111_1111;
    idle();
    rsp_ready = 1'b1;
    reset_n   = 1'b0;
    wr_valid  = 1'b1;
    rd_valid  = 1'b1;
    #2;
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst_rd_ready", {31'd0, rd_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_W0_en", {31'd0, W0_en}, 32'd0);
    chk("rst_R0_en", {31'd0, R0_en}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    idle();
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    #1;
    chk("release_rd_ready_low", {31'd0, rd_ready}, 32'd0);
    tick();
    chk("alive_wr_ready", {31'd0, wr_ready}, 32'd1);

    // Back-to-back reads 0..7 with rsp_ready held high
    for (int i = 0; i < 9; i++) begin
      rd_valid = (i < 8);
      rd_addr  = 10'(i);
      #1;
      if (i < 8) chk("b2b_rd_ready", {31'd0, rd_ready}, 32'd1);
      if (i >= 1) begin
        chk("b2b_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("b2b_rsp_data", rsp_data, (i - 1) * 32'h1111_1111);
      end
      tick();
    end
    idle();
    #1;
    chk("b2b_drained", {31'd0, rsp_valid}, 32'd0);

    // Backpressure: two reads fill the credit window
    rsp_ready = 1'b0;
    rd_valid  = 1'b1;
    rd_addr   = 10'd3;
    #1;
    chk("bp_rd_ready_0", {31'd0, rd_ready}, 32'd1);
    tick();
    rd_addr = 10'd4;
    #1;
    chk("bp_rd_ready_1", {31'd0, rd_ready}, 32'd1);
    chk("bp_fall_through", rsp_data, 32'h3333_3333);
    tick();
    rd_addr = 10'd6;
    #1;
    chk("bp_rd_ready_full", {31'd0, rd_ready}, 32'd0);
    chk("bp_R0_en_blocked", {31'd0, R0_en}, 32'd0);
    chk("bp_head", rsp_data, 32'h3333_3333);
    tick();
    rd_valid  = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("bp_rd_ready_still_full", {31'd0, rd_ready}, 32'd0);
    chk("bp_pop0", rsp_data, 32'h3333_3333);
    tick();
    #1;
    chk("bp_rd_ready_back", {31'd0, rd_ready}, 32'd1);
    chk("bp_pop1_vld", {31'd0, rsp_valid}, 32'd1);
    chk("bp_pop1", rsp_data, 32'h4444_4444);
    tick();
    chk("bp_empty", {31'd0, rsp_valid}, 32'd0);

    // Same-cycle write/read collision to address 5
    mem[5]   = 32'hAABB_CCDD;
    wr_valid = 1'b1;
    wr_addr  = 10'd5;
    wr_data  = 32'h1122_3344;
    wr_mask  = 4'b0101;
    rd_valid = 1'b1;
    rd_addr  = 10'd5;
    #1;
    chk("col_W0_en", {31'd0, W0_en}, 32'd1);
    chk("col_R0_en", {31'd0, R0_en}, 32'd1);
    tick();
    idle();
    rd_valid = 1'b1;
    rd_addr  = 10'd5;
    #1;
    chk("col_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("col_merged", rsp_data, 32'hAA22_CC44);
    tick();
    idle();
    #1;
    chk("col_reread", rsp_data, 32'hAA22_CC44);

    // Write in N, read same address in N+1
    wr_valid = 1'b1;
    wr_addr  = 10'd9;
    wr_data  = 32'hDEAD_BEEF;
    wr_mask  = 4'hF;
    tick();
    idle();
    rd_valid = 1'b1;
    rd_addr  = 10'd9;
    tick();
    idle();
    #1;
    chk("war_rsp", rsp_data, 32'hDEAD_BEEF);
    tick();

    // Reset with one buffered and one in-flight response
    rsp_ready = 1'b0;
    rd_valid  = 1'b1;
    rd_addr   = 10'd1;
    tick();
    rd_addr = 10'd2;
    tick();
    idle();
    reset_n  = 1'b0;
    wr_valid = 1'b1;
    rd_valid = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_W0_en", {31'd0, W0_en}, 32'd0);
    chk("mid_rst_R0_en", {31'd0, R0_en}, 32'd0);
    chk("mid_rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("mid_rst_rd_ready", {31'd0, rd_ready}, 32'd0);
    tick();
    idle();
    reset_n   = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("post_rst_rd_ready_low", {31'd0, rd_ready}, 32'd0);
    chk("post_rst_no_rsp0", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("post_rst_rd_ready", {31'd0, rd_ready}, 32'd1);
    chk("post_rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("post_rst_no_rsp1", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("post_rst_no_rsp2", {31'd0, rsp_valid}, 32'd0);

`ifdef SRAM_ADAPTER_PERF_EN
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    tick();
    chk("perf_rd_clr", perf_rd_cnt, 32'd0);
    rsp_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      rd_valid  = (c < 4) || (c == 5) || (c == 6);
      wr_valid  = (c < 3);
      wr_addr   = 10'd100;
      wr_mask   = 4'hF;
      rd_addr   = 10'(c);
      rsp_ready = (c >= 4);
      tick();
    end
    idle();
    rsp_ready = 1'b1;
    tick();
    tick();
    chk("perf_rd", perf_rd_cnt, 32'd4);
    chk("perf_wr", perf_wr_cnt, 32'd3);
    chk("perf_stall", perf_stall_cnt, 32'd2);
    reset_n = 1'b0;
    #1;
    chk("perf_rd_rst", perf_rd_cnt, 32'd0);
    chk("perf_wr_rst", perf_wr_cnt, 32'd0);
    chk("perf_stall_rst", perf_stall_cnt, 32'd0);
    reset_n = 1'b1;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
